// File: rtl/approx_seq_divider.sv
// Sequential restoring divider (DW-bit dividend / VW-bit divisor), one quotient bit per cycle.
// Define DIV_APPROX_EN to skip the last APPROX_BITS iterations (approximate mode).
module approx_seq_divider #(
  parameter int unsigned DW          = 8,
  parameter int unsigned VW          = 4,
  parameter int unsigned APPROX_BITS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

`ifdef DIV_APPROX_EN
  localparam int unsigned ITERS = DW - APPROX_BITS;
`else
  localparam int unsigned ITERS = DW;
`endif
  localparam int unsigned CW = $clog2(DW) + 1;

  if (APPROX_BITS >= DW || VW > DW) begin : g_bad_params
    $error("approx_seq_divider: need VW <= DW and APPROX_BITS < DW");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] q;
  logic [VW-1:0] d;
  logic [VW:0]   r;
  logic [CW-1:0] cnt;

  logic [VW:0]   r_shift;
  logic [VW:0]   r_next;
  logic [DW-1:0] q_next;
  logic          ge;
  logic          last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One restoring step; R keeps an extra bit so the compare cannot overflow.
  always_comb begin
    r_shift = {r[VW-1:0], q[DW-1]};
    ge      = (r_shift >= {1'b0, d});
    r_next  = ge ? (r_shift - {1'b0, d}) : r_shift;
    q_next  = {q[DW-2:0], ge};
    last    = (cnt == CW'(ITERS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
      CALC: if (last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q   <= dividend;
            d   <= divisor;
            r   <= '0;
            cnt <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[VW-1:0];
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          q   <= q_next;
          r   <= r_next;
          cnt <= cnt + 1'b1;
          if (last) begin
`ifdef DIV_APPROX_EN
            // Low ITERS bits of q_next hold the quotient of the truncated dividend;
            // the untouched dividend bits above them shift out, leaving zero fill.
            quotient <= q_next << APPROX_BITS;
`else
            quotient <= q_next;
`endif
            remainder <= r_next[VW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
